gear_stream_router: RTL and testbench
=====================================

Name: gear_stream_router

Overview:
- Single-clock, parametrised successor to the gear-steered demodulator data path.
- Decodes the downlink gear code into a mode: NONE, HS (cut-through) or ML (store-and-forward by frame).
- Buffers the byte stream in one internal FIFO and paces its readout by downstream ready.
- On a debounced gear change, drains, flushes and pulses the P2S reset before resuming in the new mode.

Parameters:
- DATA_W, 8, data word width.
- FIFO_DEPTH, 4096, FIFO entries; must be a power of 2.
- FRAME_LEN, 1024, ML frame length in words; 1..FIFO_DEPTH.
- HS_LO / HS_HI, 8'h42 / 8'h48, inclusive HS gear code range.
- ML_LO / ML_HI, 8'h49 / 8'h52, inclusive ML gear code range.
- ML_HOLE, 8'h50, code inside the ML range decoded as NONE.
- GEAR_STABLE, 4, cycles a new code must hold before it is accepted.
- P2S_RST_CYC, 16, o_p2s_rstn low-pulse length in cycles.
- DRAIN_TMO, 65535, maximum DRAIN cycles before a forced flush.

Ports:
- i_clk100m  in  1  sole clock.
- i_rst  in  1  synchronous, active-high reset.
- i_down_gear  in  8  gear code, already in the i_clk100m domain.
- i_data  in  DATA_W  input word.
- i_data_en  in  1  input word strobe.
- i_ready  in  1  downstream permits one pop this cycle.
- o_data  out  DATA_W  output word.
- o_data_valid  out  1  o_data valid strobe.
- o_p2s_rstn  out  1  active-low reset to the downstream P2S.
- o_mode  out  2  accepted mode: 0 = NONE, 1 = HS, 2 = ML.
- o_overflow  out  1  sticky; a word was dropped.
- o_fifo_level  out  $clog2(FIFO_DEPTH)+1  current FIFO occupancy.

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - o_data=0, o_data_valid=0, o_p2s_rstn=0, o_mode=0, o_overflow=0, o_fifo_level=0.
  - FIFO pointers, frame counters and the debounce counter are cleared; state is IDLE.
  - o_p2s_rstn goes to 1 on the first cycle after reset is released.
  - Reset asserted mid-frame or mid-drain aborts immediately; no words are emitted afterwards.
- Gear decode:
  - HS when HS_LO <= code <= HS_HI.
  - ML when ML_LO <= code <= ML_HI and code != ML_HOLE.
  - Otherwise NONE.
- Debounce:
  - A code whose decoded mode differs from o_mode must hold for GEAR_STABLE consecutive cycles; only then is a change request raised.
  - A code that reverts before the count completes resets the count; no change occurs.
  - A code change that maps to the same mode is ignored.
- States:
  - IDLE: no writes, no reads. An accepted mode != NONE goes to FLUSH.
  - RUN: writes and reads per the mode rules below. A change request goes to DRAIN.
  - DRAIN: writes blocked; reads continue per the old mode's rules. Goes to FLUSH when either:
    - no readable data remains (HS: FIFO empty; ML: frame credit = 0), or
    - DRAIN_TMO cycles elapse.
  - FLUSH: one cycle; clears pointers, the partial-frame counter and credit; latches the new mode into o_mode; goes to P2S_RST.
  - P2S_RST: o_p2s_rstn=0 for exactly P2S_RST_CYC cycles; then RUN if o_mode != NONE, else IDLE.
- Write: occurs when i_data_en && state==RUN && !full.
  - full is sampled at the start of the cycle; a simultaneous pop does not admit the write.
  - A blocked write while full sets o_overflow.
- HS read: pop when !empty && i_ready && state in {RUN, DRAIN}.
- ML read:
  - Every FRAME_LEN words written increments a frame credit.
  - Pops require credit > 0 && i_ready.
  - The credit decrements after FRAME_LEN pops.
  - A partial frame left in DRAIN is discarded by FLUSH and never emitted.
- Output timing: the pop at cycle N gives o_data_valid=1 with the word at cycle N+1 (one-cycle latency), independent of i_ready at N+1. Otherwise o_data_valid=0 and o_data holds its last value.
- Level: o_fifo_level changes by +1 on write, -1 on pop, 0 on both; it is exact in all states.
- Pointers wrap modulo FIFO_DEPTH; full and empty are distinguished by an extra pointer MSB.

Optional Feature:
- Macro: GEAR_ROUTER_DROP_CNT_EN.
- Defined:
  - Adds port o_drop_cnt (out, 16): counts words dropped by full-FIFO writes and by FLUSH discards (partial frame and drain-timeout residue).
  - Saturates at 16'hFFFF; cleared only by i_rst.
- Undefined: port and logic are absent; o_overflow behaviour is unchanged.

Test Plan:
- HS cut-through: gear 8'h44 for 4 cycles, then bytes 0x00..0x0F with i_ready=1 -> P2S pulse of 16 cycles low; o_mode=1; each byte appears on o_data one cycle after its pop; no loss.
- ML frame gating (FRAME_LEN=8): gear 8'h4A; write 12 words with i_ready=1 -> exactly 8 words output; o_fifo_level=4 holds; 4 more writes -> 8 more words output.
- Debounce and hole: gear 8'h44 -> 8'h4A for 3 cycles -> 8'h44 -> no DRAIN and o_mode stays 1; gear 8'h50 held for 4 cycles -> DRAIN, then o_mode=0 and IDLE.
- ML to HS with a partial frame: 5 of 8 words written, then gear 8'h42 -> the 5 words are never emitted; o_p2s_rstn low 16 cycles; o_mode=1; o_drop_cnt=5 if enabled.
- Overflow (FIFO_DEPTH=16, HS, i_ready=0): 20 writes -> o_fifo_level=16; o_overflow=1 stays set; a write on the same cycle as a pop when full is dropped.
- Reset mid-drain: i_rst pulsed during DRAIN with 6 words queued -> next cycle all outputs at reset values; o_data_valid stays 0 until a new mode is accepted.

Source files
------------

// File: rtl/gear_stream_router.sv
// rtl/gear_stream_router.sv - gear-steered byte stream router (HS cut-through / ML store-and-forward); optional GEAR_ROUTER_DROP_CNT_EN
module gear_stream_router #(
    parameter int         DATA_W      = 8,
    parameter int         FIFO_DEPTH  = 4096,
    parameter int         FRAME_LEN   = 1024,
    parameter logic [7:0] HS_LO       = 8'h42,
    parameter logic [7:0] HS_HI       = 8'h48,
    parameter logic [7:0] ML_LO       = 8'h49,
    parameter logic [7:0] ML_HI       = 8'h52,
    parameter logic [7:0] ML_HOLE     = 8'h50,
    parameter int         GEAR_STABLE = 4,
    parameter int         P2S_RST_CYC = 16,
    parameter int         DRAIN_TMO   = 65535
) (
    input  logic                          i_clk100m,
    input  logic                          i_rst,
    input  logic [7:0]                    i_down_gear,
    input  logic [DATA_W-1:0]             i_data,
    input  logic                          i_data_en,
    input  logic                          i_ready,
    output logic [DATA_W-1:0]             o_data,
    output logic                          o_data_valid,
    output logic                          o_p2s_rstn,
    output logic [1:0]                    o_mode,
    output logic                          o_overflow,
    output logic [$clog2(FIFO_DEPTH):0]   o_fifo_level
`ifdef GEAR_ROUTER_DROP_CNT_EN
    ,
    output logic [15:0]                   o_drop_cnt
`endif
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int FW = $clog2(FRAME_LEN + 1);
    localparam int CW = $clog2(GEAR_STABLE + 1);
    localparam logic [1:0] M_NONE = 2'd0;
    localparam logic [1:0] M_HS   = 2'd1;
    localparam logic [1:0] M_ML   = 2'd2;

    typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_FLUSH, S_P2S} state_t;

    state_t              state_q, state_d;
    logic [1:0]          mode_q, new_mode_q, new_mode_d;
    logic [1:0]          cand_q, dec_mode;
    logic [CW-1:0]       cnt_q;
    logic [31:0]         tmr_q;
    logic [AW:0]         wr_ptr_q, rd_ptr_q;
    logic [LW-1:0]       level_q, credit_q;
    logic [FW-1:0]       fcnt_wr_q, fcnt_rd_q;
    logic [DATA_W-1:0]   data_q;
    logic                valid_q, p2s_q, ovf_q;
    logic [DATA_W-1:0]   mem [FIFO_DEPTH];
    logic                full, empty, ml, active, pop, wr, blocked, req, frm_wr, frm_rd;

    assign dec_mode = (i_down_gear >= HS_LO && i_down_gear <= HS_HI) ? M_HS :
                      (i_down_gear >= ML_LO && i_down_gear <= ML_HI && i_down_gear != ML_HOLE) ? M_ML : M_NONE;

    // extra MSB tells full from empty when the low pointer bits match
    assign full    = (wr_ptr_q[AW] != rd_ptr_q[AW]) && (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign ml      = (mode_q == M_ML);
    assign active  = (state_q == S_RUN) || (state_q == S_DRAIN);
    assign pop     = active && i_ready && (ml ? (credit_q != '0) : !empty);
    assign wr      = i_data_en && (state_q == S_RUN) && !full;
    assign blocked = i_data_en && (state_q == S_RUN) && full;
    assign req     = (cnt_q == CW'(GEAR_STABLE));
    assign frm_wr  = ml && wr && (fcnt_wr_q == FW'(FRAME_LEN - 1));
    assign frm_rd  = ml && pop && (fcnt_rd_q == FW'(FRAME_LEN - 1));

    // debounce: a differing mode must persist for GEAR_STABLE cycles before a change request
    always_ff @(posedge i_clk100m) begin
        if (i_rst || state_q == S_FLUSH) begin
            cand_q <= M_NONE;
            cnt_q  <= '0;
        end else if (dec_mode == mode_q) begin
            cnt_q <= '0;
        end else if (dec_mode == cand_q && cnt_q != '0) begin
            if (!req) cnt_q <= cnt_q + CW'(1);
        end else begin
            cand_q <= dec_mode;
            cnt_q  <= CW'(1);
        end
    end

    // next-state logic for the mode-change sequence
    always_comb begin
        state_d    = state_q;
        new_mode_d = new_mode_q;
        case (state_q)
            S_IDLE: if (req) begin
                new_mode_d = cand_q;
                state_d    = S_FLUSH;
            end
            S_RUN: if (req) begin
                new_mode_d = cand_q;
                state_d    = S_DRAIN;
            end
            S_DRAIN: if ((ml ? (credit_q == '0) : empty) || tmr_q == 32'(DRAIN_TMO - 1))
                state_d = S_FLUSH;
            S_FLUSH: state_d = S_P2S;
            S_P2S: if (tmr_q == 32'(P2S_RST_CYC - 1))
                state_d = (mode_q != M_NONE) ? S_RUN : S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // FIFO storage; not reset, the pointers define what is valid
    always_ff @(posedge i_clk100m) begin
        if (wr) mem[wr_ptr_q[AW-1:0]] <= i_data;
    end

    // state, pointers, frame credit and registered outputs
    always_ff @(posedge i_clk100m) begin
        if (i_rst) begin
            state_q    <= S_IDLE;
            mode_q     <= M_NONE;
            new_mode_q <= M_NONE;
            tmr_q      <= '0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            credit_q   <= '0;
            fcnt_wr_q  <= '0;
            fcnt_rd_q  <= '0;
            data_q     <= '0;
            valid_q    <= 1'b0;
            p2s_q      <= 1'b0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            new_mode_q <= new_mode_d;
            tmr_q      <= (state_d != state_q) ? '0 : tmr_q + 32'd1;
            p2s_q      <= (state_d != S_P2S);
            valid_q    <= pop;
            if (pop) data_q <= mem[rd_ptr_q[AW-1:0]];
            if (blocked) ovf_q <= 1'b1;
            if (state_q == S_FLUSH) begin
                wr_ptr_q  <= '0;
                rd_ptr_q  <= '0;
                level_q   <= '0;
                credit_q  <= '0;
                fcnt_wr_q <= '0;
                fcnt_rd_q <= '0;
                mode_q    <= new_mode_q;
            end else begin
                if (wr)  wr_ptr_q <= wr_ptr_q + 1'b1;
                if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
                level_q <= level_q + LW'(wr) - LW'(pop);
                if (ml) begin
                    if (wr)  fcnt_wr_q <= frm_wr ? '0 : fcnt_wr_q + FW'(1);
                    if (pop) fcnt_rd_q <= frm_rd ? '0 : fcnt_rd_q + FW'(1);
                    credit_q <= credit_q + LW'(frm_wr) - LW'(frm_rd);
                end
            end
        end
    end

`ifdef GEAR_ROUTER_DROP_CNT_EN
    logic [15:0] drop_q;
    logic [16:0] drop_sum;

    // dropped words: full-FIFO writes plus whatever FLUSH throws away
    always_comb begin
        drop_sum = {1'b0, drop_q};
        if (blocked) drop_sum = drop_sum + 17'd1;
        if (state_q == S_FLUSH) drop_sum = drop_sum + 17'(level_q);
    end

    // saturating drop counter, cleared only by reset
    always_ff @(posedge i_clk100m) begin
        if (i_rst) drop_q <= '0;
        else       drop_q <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    assign o_drop_cnt = drop_q;
`endif

    assign o_data       = data_q;
    assign o_data_valid = valid_q;
    assign o_p2s_rstn   = p2s_q;
    assign o_mode       = mode_q;
    assign o_overflow   = ovf_q;
    assign o_fifo_level = level_q;
endmodule

// File: tb/tb_gear_stream_router.sv
// tb/tb_gear_stream_router.sv - randomized scoreboard bench for gear_stream_router
`timescale 1ns/1ps
module tb_gear_stream_router;
    localparam int DEPTH = 16;
    localparam int FL    = 8;
    localparam int TMO   = 40;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] gear = 8'h00;
    logic [7:0] din = 8'h00;
    logic       den = 1'b0;
    logic       rdy = 1'b0;
    logic [7:0] o_data;
    logic       o_data_valid, o_p2s_rstn, o_overflow;
    logic [1:0] o_mode;
    logic [4:0] o_fifo_level;
`ifdef GEAR_ROUTER_DROP_CNT_EN
    logic [15:0] o_drop_cnt;
`endif

    gear_stream_router #(.FIFO_DEPTH(DEPTH), .FRAME_LEN(FL), .DRAIN_TMO(TMO)) dut (
        .i_clk100m(clk), .i_rst(rst), .i_down_gear(gear), .i_data(din), .i_data_en(den),
        .i_ready(rdy), .o_data(o_data), .o_data_valid(o_data_valid), .o_p2s_rstn(o_p2s_rstn),
        .o_mode(o_mode), .o_overflow(o_overflow), .o_fifo_level(o_fifo_level)
`ifdef GEAR_ROUTER_DROP_CNT_EN
        , .o_drop_cnt(o_drop_cnt)
`endif
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [7:0] exp_q[$];
    logic [7:0] mq[$];
    int  m_mode = 0, m_wr = 0, m_rd = 0, m_drop = 0;
    bit  m_run = 0, m_ovf = 0;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, expv);
        end
    endtask

    // monitor: every presented word must be the next one the model released
    always @(negedge clk) begin
        logic [7:0] e;
        if (o_data_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_word: got %0h expected none", o_data);
            end else begin
                e = exp_q.pop_front();
                check("data", o_data, e);
            end
        end
    end

    // one cycle: reference model decides pop and write from queue contents and frame arithmetic
    task automatic cyc(input bit en, input logic [7:0] d, input bit r, input bit chk);
        bit full, canpop;
        din = d;
        den = en;
        rdy = r;
        full = (mq.size() == DEPTH);
        if (m_mode == 2) canpop = (m_rd < (m_wr / FL) * FL);
        else             canpop = (m_mode == 1) && (mq.size() > 0);
        if (r && canpop) begin
            exp_q.push_back(mq.pop_front());
            m_rd++;
        end
        if (en && m_run) begin
            if (!full) begin
                mq.push_back(d);
                m_wr++;
            end else begin
                m_ovf = 1;
                m_drop++;
            end
        end
        @(posedge clk);
        #1;
        if (chk) check("level", o_fifo_level, mq.size());
    endtask

    task automatic check_drop();
`ifdef GEAR_ROUTER_DROP_CNT_EN
        check("drop_cnt", o_drop_cnt, m_drop);
`endif
    endtask

    // request a new gear, follow drain/flush, then measure the P2S pulse
    task automatic gear_change(input logic [7:0] g, input bit r, input int newmode);
        int n, low;
        gear = g;
        m_run = 0;
        n = 0;
        while (o_p2s_rstn !== 1'b0 && n < 200) begin
            cyc(0, 8'h00, r, 0);
            n++;
        end
        check("p2s_fall", o_p2s_rstn, 1'b0);
        m_drop += mq.size();
        mq.delete();
        m_wr = 0;
        m_rd = 0;
        m_mode = newmode;
        low = 0;
        while (o_p2s_rstn === 1'b0 && low < 100) begin
            low++;
            cyc(0, 8'h00, r, 1);
        end
        check("p2s_len", low, 16);
        check("mode", o_mode, newmode);
        m_run = (newmode != 0);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        // reset values
        repeat (2) @(posedge clk);
        #1;
        check("rst_data", o_data, 0);
        check("rst_valid", o_data_valid, 0);
        check("rst_p2s", o_p2s_rstn, 0);
        check("rst_mode", o_mode, 0);
        check("rst_ovf", o_overflow, 0);
        check("rst_level", o_fifo_level, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check("p2s_after_rst", o_p2s_rstn, 1);

        // HS cut-through, ordered bytes then random traffic
        gear_change(8'h44, 1, 1);
        for (int i = 0; i < 16; i++) cyc(1, 8'(i), 1, 1);
        repeat (3) cyc(0, 8'h00, 1, 1);
        check("hs_all_out", exp_q.size(), 0);
        repeat (60) cyc(1'($urandom % 2), 8'($urandom), 1'(($urandom % 4) != 0), 1);
        repeat (20) cyc(0, 8'h00, 1, 1);
        check("hs_rand_out", exp_q.size(), 0);
        check("hs_ovf", o_overflow, m_ovf);

        // debounce: short ML excursion is ignored
        gear = 8'h4A;
        repeat (3) cyc(0, 8'h00, 1, 1);
        gear = 8'h44;
        repeat (10) begin
            cyc(0, 8'h00, 1, 1);
            check("deb_p2s", o_p2s_rstn, 1);
        end
        check("deb_mode", o_mode, 1);

        // ML frame gating
        gear_change(8'h4A, 1, 2);
        repeat (12) cyc(1, 8'($urandom), 1, 1);
        repeat (5) cyc(0, 8'h00, 1, 1);
        check("ml_hold_level", o_fifo_level, 4);
        check("ml_first_frame", exp_q.size(), 0);
        repeat (4) cyc(1, 8'($urandom), 1, 1);
        repeat (12) cyc(0, 8'h00, 1, 1);
        check("ml_second_frame", exp_q.size(), 0);
        repeat (40) cyc(1'($urandom % 2), 8'($urandom), 1'($urandom % 2), 1);
        n = 0;
        while ((m_wr % FL) != 0 && n < 100) begin
            cyc(1, 8'($urandom), 1, 1);
            n++;
        end
        repeat (30) cyc(0, 8'h00, 1, 1);
        check("ml_rand_out", exp_q.size(), 0);

        // ML to HS with a partial frame that must be discarded
        repeat (5) cyc(1, 8'($urandom), 1, 1);
        gear_change(8'h42, 1, 1);
        check_drop();
        repeat (4) cyc(0, 8'h00, 1, 1);
        check("partial_gone", exp_q.size(), 0);

        // ML hole decodes to NONE -> IDLE, writes ignored
        gear_change(8'h50, 1, 0);
        repeat (8) cyc(1, 8'($urandom), 1, 1);
        check("idle_mode", o_mode, 0);
        check("idle_p2s", o_p2s_rstn, 1);

        // overflow with i_ready low, then pop-while-full, then drain timeout
        gear_change(8'h44, 0, 1);
        repeat (20) cyc(1, 8'($urandom), 0, 1);
        check("ovf_level", o_fifo_level, 16);
        check("ovf_flag", o_overflow, 1);
        cyc(1, 8'($urandom), 1, 1);
        check("ovf_pop_full", o_fifo_level, 15);
        check("ovf_sticky", o_overflow, 1);
        check_drop();
        gear_change(8'h4A, 0, 2);
        check_drop();
        check("tmo_ovf", o_overflow, m_ovf);

        // reset in the middle of a drain
        gear_change(8'h44, 1, 1);
        repeat (6) cyc(1, 8'($urandom), 0, 1);
        gear = 8'h49;
        repeat (7) cyc(0, 8'h00, 0, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        mq.delete();
        exp_q.delete();
        m_mode = 0; m_wr = 0; m_rd = 0; m_drop = 0; m_run = 0; m_ovf = 0;
        check("mrst_data", o_data, 0);
        check("mrst_valid", o_data_valid, 0);
        check("mrst_p2s", o_p2s_rstn, 0);
        check("mrst_mode", o_mode, 0);
        check("mrst_ovf", o_overflow, 0);
        check("mrst_level", o_fifo_level, 0);
        check_drop();
        gear = 8'h00;
        rst = 1'b0;
        repeat (10) begin
            cyc(0, 8'h00, 1, 1);
            check("mrst_quiet", o_data_valid, 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
